// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// optional parity, 1 or 2 stop bits, one-entry output register with valid/ack handshake.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 RX,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    // The counter restarts at the start-bit decision, so later bit centres sit at OVERSAMPLE-2.
    localparam logic [TW-1:0] START_LO   = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] BIT_LO     = TW'(OVERSAMPLE - 3);
    localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP  = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
        logic mismatch;
        mismatch = (^d) ^ p;
        return (PARITY_ODD != 0) ? ~mismatch : mismatch;
    endfunction

    logic                 rx_meta;
    logic                 rx_s;
    state_t               state_q;
    state_t               state_d;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic [1:0]           samp_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic [TW-1:0]        win_lo;
    logic [TW-1:0]        win_last;
    logic                 sampling;
    logic                 in_win;
    logic                 at_last;
    logic                 vote;
    logic                 bit_done;
    logic                 commit;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    assign sampling = (state_q == START) || (state_q == DATA) ||
                      (state_q == PARITY) || (state_q == STOP);
    assign win_lo   = (state_q == START) ? START_LO : BIT_LO;
    assign win_last = (state_q == START) ? START_LAST : BIT_LAST;
    assign in_win   = (tick_cnt >= win_lo) && (tick_cnt <= win_last);
    assign at_last  = (tick_cnt == win_last);
    // The third capture is the live rx_s, so the vote resolves on the closing tick itself.
    assign vote     = majority3(samp_q[1], samp_q[0], rx_s);
    assign bit_done = sample_tick && sampling && at_last;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_tick && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_cnt == LAST_DATA)) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done && (stop_cnt == LAST_STOP)) begin
                    commit  = 1'b1;
                    // A low final stop bit means a break: hold off until the line idles again.
                    state_d = vote ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (sample_tick && rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            samp_q    <= 2'b11;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) || (state_q == WAIT_HIGH)) begin
                tick_cnt <= '0;
            end else if (sample_tick) begin
                tick_cnt <= bit_done ? '0 : tick_cnt + 1'b1;
            end

            if (sample_tick && sampling && in_win && !at_last) begin
                samp_q <= {samp_q[0], rx_s};
            end

            if (state_q != DATA) begin
                bit_cnt <= '0;
            end else if (bit_done) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state_q != STOP) begin
                stop_cnt <= 1'b0;
            end else if (bit_done) begin
                stop_cnt <= 1'b1;
            end

            if ((state_q == DATA) && bit_done) begin
                shift_q <= {vote, shift_q[DATA_BITS-1:1]};
            end

            if (state_q == START) begin
                par_err_q <= 1'b0;
                frm_err_q <= 1'b0;
            end else if (bit_done && (state_q == PARITY)) begin
                par_err_q <= parity_error(shift_q, vote);
            end else if (bit_done && (state_q == STOP) && !vote) begin
                frm_err_q <= 1'b1;
            end
        end
    end

    // An ack landing on the commit cycle frees the slot, so the new word loads without overrun.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= commit && rx_valid && !rx_ack;
            if (commit && (!rx_valid || rx_ack)) begin
                data_out   <= shift_q;
                parity_err <= par_err_q;
                frame_err  <= frm_err_q | ~vote;
                rx_valid   <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven with directed and random frames,
// checked against a frame-level model of the received word, flags and handshake.
module tb_uart_rx_param;

    logic       sys_clk = 1'b0;
    logic       reset_n;
    logic       sample_tick;
    logic [2:0] rx;
    logic [2:0] ack;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [8:0] d2;
    logic [2:0] vld, pe, fe, ov, bsy;

    int vectors = 0;
    int miscompares = 0;

    bit         line_q[$];
    logic       exp_vld [3];
    logic [8:0] exp_data[3];
    logic       exp_pe  [3];
    logic       exp_fe  [3];

    always #5 sys_clk = ~sys_clk;

    uart_rx_param u0 (
        .sys_clk(sys_clk), .reset_n(reset_n), .sample_tick(sample_tick), .RX(rx[0]),
        .rx_ack(ack[0]), .data_out(d0), .rx_valid(vld[0]), .parity_err(pe[0]),
        .frame_err(fe[0]), .overrun_err(ov[0]), .busy(bsy[0])
    );

    uart_rx_param #(.PARITY_EN(1)) u1 (
        .sys_clk(sys_clk), .reset_n(reset_n), .sample_tick(sample_tick), .RX(rx[1]),
        .rx_ack(ack[1]), .data_out(d1), .rx_valid(vld[1]), .parity_err(pe[1]),
        .frame_err(fe[1]), .overrun_err(ov[1]), .busy(bsy[1])
    );

    uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(1),
                    .STOP_BITS(2)) u2 (
        .sys_clk(sys_clk), .reset_n(reset_n), .sample_tick(sample_tick), .RX(rx[2]),
        .rx_ack(ack[2]), .data_out(d2), .rx_valid(vld[2]), .parity_err(pe[2]),
        .frame_err(fe[2]), .overrun_err(ov[2]), .busy(bsy[2])
    );

    function automatic int cfg_os(input int s);    return (s == 2) ? 8 : 16; endfunction
    function automatic int cfg_nb(input int s);    return (s == 2) ? 9 : 8;  endfunction
    function automatic int cfg_pen(input int s);   return (s != 0) ? 1 : 0;  endfunction
    function automatic int cfg_podd(input int s);  return (s == 2) ? 1 : 0;  endfunction
    function automatic int cfg_stops(input int s); return (s == 2) ? 2 : 1;  endfunction

    function automatic logic [8:0] dsel(input int s);
        case (s)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            default: return d2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            rx = 3'b111;
            ack = 3'b000;
            sample_tick = 1'b1;
        end
    endtask

    task automatic do_ack(input int s);
        @(negedge sys_clk);
        ack[s] = 1'b1;
        @(negedge sys_clk);
        ack[s] = 1'b0;
        exp_vld[s] = 1'b0;
        chk($sformatf("u%0d_ack_clears_valid", s), 32'(vld[s]), 32'(0));
    endtask

    // Builds the line waveform (one entry per bit period) and the frame-level expectations.
    task automatic build_line(input int s, input logic [8:0] data, input bit bad_par,
                              input bit bad_stop1, input bit bad_stop_last,
                              output logic [8:0] dm, output bit new_pe, output bit new_fe,
                              output int commit_edge);
        int nb = cfg_nb(s);
        int st = cfg_stops(s);
        bit par;
        bit sb;
        dm = data & 9'((1 << nb) - 1);
        par = ^dm;
        if (cfg_podd(s) != 0) par = ~par;
        if (bad_par) par = ~par;
        line_q.delete();
        line_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) line_q.push_back(dm[i]);
        if (cfg_pen(s) != 0) line_q.push_back(par);
        for (int k = 0; k < st; k++) begin
            sb = 1'b1;
            if (k == 0 && st == 2 && bad_stop1) sb = 1'b0;
            if (k == st - 1 && bad_stop_last) sb = 1'b0;
            line_q.push_back(sb);
        end
        new_pe = (cfg_pen(s) != 0) && bad_par;
        new_fe = (st == 2 && bad_stop1) || bad_stop_last;
        // 2 synchroniser cycles + detect tick, start vote, then one bit period per remaining bit.
        commit_edge = cfg_os(s) / 2 + 4 + (nb + cfg_pen(s) + st) * cfg_os(s);
    endtask

    // Line advances one position per tick; observation at negedge n sees the state after edge n.
    task automatic drive_frame(input int s, input int tick_pct, input int tail_ticks,
                               input bit tail_val, input int ack_edge, input int max_n,
                               output int rise_edge, output int ov_cnt);
        int os = cfg_os(s);
        int total = line_q.size() * os + tail_ticks;
        int pos = 0;
        int n = 0;
        bit prev;
        bit tk;
        rise_edge = -1;
        ov_cnt = 0;
        prev = vld[s];
        while (pos < total && n < max_n) begin
            @(negedge sys_clk);
            if (vld[s] && !prev && rise_edge < 0) rise_edge = n;
            prev = vld[s];
            if (ov[s]) ov_cnt++;
            rx[s] = (pos < line_q.size() * os) ? line_q[pos / os] : tail_val;
            tk = (tick_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < tick_pct);
            sample_tick = tk;
            ack[s] = (n + 1 == ack_edge);
            if (tk) pos++;
            n++;
        end
        @(negedge sys_clk);
        if (vld[s] && !prev && rise_edge < 0) rise_edge = n;
        if (ov[s]) ov_cnt++;
        ack[s] = 1'b0;
        sample_tick = 1'b1;
    endtask

    task automatic send(input int s, input logic [8:0] data, input bit bad_par,
                        input bit bad_stop1, input bit bad_stop_last, input int tick_pct,
                        input bit ack_commit, input bit brk);
        logic [8:0] dm;
        bit new_pe, new_fe;
        int ce, rise, ovc;
        build_line(s, data, bad_par, bad_stop1, bad_stop_last, dm, new_pe, new_fe, ce);
        drive_frame(s, tick_pct, brk ? 3 * cfg_os(s) : cfg_os(s), !brk,
                    ack_commit ? ce : -1, 20000, rise, ovc);
        if (!exp_vld[s] || ack_commit) begin
            if (tick_pct >= 100 && !exp_vld[s])
                chk($sformatf("u%0d_commit_edge", s), 32'(rise), 32'(ce));
            exp_vld[s]  = 1'b1;
            exp_data[s] = dm;
            exp_pe[s]   = new_pe;
            exp_fe[s]   = new_fe;
            chk($sformatf("u%0d_no_overrun", s), 32'(ovc), 32'(0));
        end else begin
            chk($sformatf("u%0d_overrun_pulse", s), 32'(ovc), 32'(1));
        end
        chk($sformatf("u%0d_valid", s), 32'(vld[s]), 32'(exp_vld[s]));
        chk($sformatf("u%0d_data", s), 32'(dsel(s)), 32'(exp_data[s]));
        chk($sformatf("u%0d_parity_err", s), 32'(pe[s]), 32'(exp_pe[s]));
        chk($sformatf("u%0d_frame_err", s), 32'(fe[s]), 32'(exp_fe[s]));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, tp, rise, ovc, seen_busy, seen_vld;
        logic [8:0] d, dm;
        bit bp, bs1, bsl, ac, npe, nfe;
        int ce;

        reset_n = 1'b0;
        rx = 3'b111;
        ack = 3'b000;
        sample_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_vld[i] = 1'b0; exp_data[i] = '0; exp_pe[i] = 1'b0; exp_fe[i] = 1'b0;
        end
        repeat (3) @(negedge sys_clk);
        chk("rst_valid", 32'(vld), 32'(0));
        chk("rst_busy", 32'(bsy), 32'(0));
        chk("rst_parity_err", 32'(pe), 32'(0));
        chk("rst_frame_err", 32'(fe), 32'(0));
        chk("rst_overrun", 32'(ov), 32'(0));
        chk("rst_data0", 32'(d0), 32'(0));
        chk("rst_data1", 32'(d1), 32'(0));
        chk("rst_data2", 32'(d2), 32'(0));
        reset_n = 1'b1;
        drive_idle(4);

        // Plain 8N1 frame, then acknowledge
        send(0, 9'h0A5, 0, 0, 0, 100, 0, 0);
        chk("u0_busy_after_commit", 32'(bsy[0]), 32'(0));
        do_ack(0);

        // Start-bit glitch: 4 low ticks must be rejected by the vote
        seen_busy = 0;
        seen_vld = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (bsy[0]) seen_busy = 1;
            if (vld[0]) seen_vld = 1;
            rx[0] = (i < 4) ? 1'b0 : 1'b1;
        end
        chk("glitch_busy_seen", 32'(seen_busy), 32'(1));
        chk("glitch_no_valid", 32'(seen_vld), 32'(0));
        chk("glitch_busy_end", 32'(bsy[0]), 32'(0));

        // Even parity: 0x03 with parity bit 1 is an error, with parity bit 0 it is clean
        send(1, 9'h003, 1, 0, 0, 100, 0, 0);
        do_ack(1);
        send(1, 9'h003, 0, 0, 0, 100, 0, 0);
        do_ack(1);

        // Break: stop bit low and line held low for 3 bit times
        send(0, 9'h05A, 0, 0, 1, 100, 0, 1);
        chk("brk_busy_low_line", 32'(bsy[0]), 32'(1));
        drive_idle(2);
        chk("brk_busy_before_sync", 32'(bsy[0]), 32'(1));
        drive_idle(6);
        chk("brk_busy_released", 32'(bsy[0]), 32'(0));
        do_ack(0);
        send(0, 9'h03C, 0, 0, 0, 100, 0, 0);
        do_ack(0);

        // Overrun without ack, then ack on the exact commit cycle
        send(0, 9'h011, 0, 0, 0, 100, 0, 0);
        send(0, 9'h022, 0, 0, 0, 100, 0, 0);
        do_ack(0);
        send(0, 9'h011, 0, 0, 0, 100, 0, 0);
        send(0, 9'h022, 0, 0, 0, 100, 1, 0);
        do_ack(0);

        // 9-bit odd parity, 2 stop bits, 8x oversampling; reset mid-data
        send(2, 9'h1FF, 0, 0, 0, 100, 0, 0);
        build_line(2, 9'h0C3, 0, 0, 0, dm, npe, nfe, ce);
        drive_frame(2, 100, 8, 1'b1, -1, 40, rise, ovc);
        reset_n = 1'b0;
        rx = 3'b111;
        @(negedge sys_clk);
        chk("midrst_valid", 32'(vld), 32'(0));
        chk("midrst_busy2", 32'(bsy[2]), 32'(0));
        chk("midrst_data2", 32'(d2), 32'(0));
        chk("midrst_flags2", 32'({pe[2], fe[2], ov[2]}), 32'(0));
        for (int i = 0; i < 3; i++) begin
            exp_vld[i] = 1'b0; exp_data[i] = '0; exp_pe[i] = 1'b0; exp_fe[i] = 1'b0;
        end
        @(negedge sys_clk);
        reset_n = 1'b1;
        drive_idle(4);
        send(2, 9'h12D, 0, 0, 0, 100, 0, 0);
        do_ack(2);

        // Random frames across all configurations
        for (int i = 0; i < 14; i++) begin
            s   = $urandom_range(0, 2);
            d   = 9'($urandom);
            bp  = (cfg_pen(s) != 0) && ($urandom_range(0, 3) == 0);
            bs1 = (cfg_stops(s) == 2) && ($urandom_range(0, 3) == 0);
            bsl = ($urandom_range(0, 5) == 0);
            tp  = (s == 0 && $urandom_range(0, 1) == 1) ? 70 : 100;
            ac  = (tp == 100) && exp_vld[s] && ($urandom_range(0, 1) == 1);
            send(s, d, bp, bs1, bsl, tp, ac, 0);
            if ($urandom_range(0, 2) != 0) do_ack(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
